// File: rtl/register_acc.sv
// Eleven-bit accumulator for the sequential divider/multiplier datapath.
// Each rising edge captures either the ALU result or {A, Q[9]} (A shifted left, Q MSB in).
module register_acc (
    input  logic        clock,
    input  logic        rst,
    input  logic        ldQ,
    input  logic [9:0]  A,
    input  logic [9:0]  Q,
    input  logic [10:0] value_in,
    output logic [10:0] value_out
);

    logic [10:0] shift_src;
    logic [10:0] acc_next;
    logic [10:0] acc_reg;

    // Only the MSB of Q takes part in the shift; the rest is deliberately dropped.
    logic unused_q_low;
    assign unused_q_low = ^Q[8:0];

    assign shift_src = {A, Q[9]};

    generate
        for (genvar gi = 0; gi < 11; gi++) begin : g_src_mux
            assign acc_next[gi] = ldQ ? value_in[gi] : shift_src[gi];
        end
    endgenerate

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            acc_reg <= 11'h000;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign value_out = acc_reg;

endmodule

// File: tb/tb_register_acc.sv
// Self-checking bench for register_acc: directed cases plus a randomized run
// compared against an arithmetic reference of the load/shift rule.
`timescale 1ns/1ps
module tb_register_acc;

    logic        clk;
    logic        rst;
    logic        ldQ;
    logic [9:0]  A;
    logic [9:0]  Q;
    logic [10:0] value_in;
    logic [10:0] value_out;

    int checks;
    int failures;

    register_acc dut (
        .clock    (clk),
        .rst      (rst),
        .ldQ      (ldQ),
        .A        (A),
        .Q        (Q),
        .value_in (value_in),
        .value_out(value_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: load passes the ALU value through; shift is A*2 plus the Q MSB.
    function automatic logic [10:0] model(input logic sel, input logic [10:0] vin,
                                          input logic [9:0] a, input logic [9:0] q);
        int unsigned r;
        if (sel) r = vin;
        else     r = a * 2 + (q >= 10'd512 ? 1 : 0);
        return r[10:0];
    endfunction

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ldQ = 1'b1; value_in = 11'h7FF; A = 10'h3FF; Q = 10'h3FF;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (value_out !== 11'h000) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", i, value_out, 11'h000);
            end else
                $display("reset_hold cycle %0d: value_out=%h", i, value_out);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (value_out !== 11'h7FF) begin
            failures++;
            $display("FAIL reset_release_first_load: got %h expected %h", value_out, 11'h7FF);
        end else
            $display("reset_release_first_load: value_out=%h", value_out);
    endtask

    task automatic test_async_reset();
        rst = 1'b0; ldQ = 1'b1; value_in = 11'h3A5;
        tick();
        checks++;
        if (value_out !== 11'h3A5) begin
            failures++;
            $display("FAIL async_preload: got %h expected %h", value_out, 11'h3A5);
        end else
            $display("async_preload: value_out=%h", value_out);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (value_out !== 11'h000) begin
            failures++;
            $display("FAIL async_clear_midcycle: got %h expected %h", value_out, 11'h000);
        end else
            $display("async_clear_midcycle: value_out=%h", value_out);
        #2 rst = 1'b0;
    endtask

    task automatic test_load();
        rst = 1'b0; ldQ = 1'b1; value_in = 11'h5A3;
        tick();
        checks++;
        if (value_out !== 11'h5A3) begin
            failures++;
            $display("FAIL load_5a3: got %h expected %h", value_out, 11'h5A3);
        end else
            $display("load_5a3: value_out=%h", value_out);
        value_in = 11'h001;
        tick();
        checks++;
        if (value_out !== 11'h001) begin
            failures++;
            $display("FAIL load_001: got %h expected %h", value_out, 11'h001);
        end else
            $display("load_001: value_out=%h", value_out);
    endtask

    task automatic test_shift();
        ldQ = 1'b0; A = 10'h2AB; Q = 10'h200; value_in = 11'h7FF;
        tick();
        checks++;
        if (value_out !== 11'h557) begin
            failures++;
            $display("FAIL shift_q_msb1: got %h expected %h", value_out, 11'h557);
        end else
            $display("shift_q_msb1: value_out=%h", value_out);
        Q = 10'h1FF;
        tick();
        checks++;
        if (value_out !== 11'h556) begin
            failures++;
            $display("FAIL shift_q_low_ignored: got %h expected %h", value_out, 11'h556);
        end else
            $display("shift_q_low_ignored: value_out=%h", value_out);
    endtask

    task automatic test_alternate();
        logic [10:0] exp_seq [3];
        logic        sel_seq [3];
        exp_seq[0] = 11'h100; exp_seq[1] = 11'h7FF; exp_seq[2] = 11'h100;
        sel_seq[0] = 1'b1;    sel_seq[1] = 1'b0;    sel_seq[2] = 1'b1;
        value_in = 11'h100; A = 10'h3FF; Q = 10'h3FF;
        for (int i = 0; i < 3; i++) begin
            ldQ = sel_seq[i];
            tick();
            checks++;
            if (value_out !== exp_seq[i]) begin
                failures++;
                $display("FAIL alternate step %0d: got %h expected %h", i, value_out, exp_seq[i]);
            end else
                $display("alternate step %0d ldQ=%b: value_out=%h", i, sel_seq[i], value_out);
        end
    endtask

    task automatic test_random();
        logic [10:0] expected;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ldQ      = 1'($urandom_range(0, 1));
            A        = 10'($urandom);
            Q        = 10'($urandom);
            value_in = 11'($urandom);
            expected = model(ldQ, value_in, A, Q);
            tick();
            checks++;
            if (value_out !== expected) begin
                failures++;
                $display("FAIL random %0d ldQ=%b A=%h Q=%h vin=%h: got %h expected %h",
                         i, ldQ, A, Q, value_in, value_out, expected);
            end else
                $display("random %0d ldQ=%b A=%h Q=%h vin=%h: value_out=%h",
                         i, ldQ, A, Q, value_in, value_out);
            // Disturb inputs between edges; the register must not follow them.
            #2;
            ldQ      = ~ldQ;
            A        = ~A;
            Q        = ~Q;
            value_in = ~value_in;
            #1;
            checks++;
            if (value_out !== expected) begin
                failures++;
                $display("FAIL random_between_edges %0d: got %h expected %h", i, value_out, expected);
            end else
                $display("random_between_edges %0d: value_out=%h", i, value_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] expected;
        for (int i = 0; i < 8; i++) begin
            ldQ = 1'(i % 2);
            A = 10'($urandom); Q = 10'($urandom); value_in = 11'($urandom);
            expected = model(ldQ, value_in, A, Q);
            tick();
            checks++;
            if (value_out !== expected) begin
                failures++;
                $display("FAIL back_to_back %0d: got %h expected %h", i, value_out, expected);
            end else
                $display("back_to_back %0d ldQ=%b: value_out=%h", i, ldQ, value_out);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; ldQ = 1'b0; A = '0; Q = '0; value_in = '0;
        @(negedge clk);
        test_reset();
        test_load();
        test_shift();
        test_alternate();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
